bpeb_term_serializer: RTL and testbench

//  Parametrised radix-4 Booth-pair encoder with approximation masking and essential-term serialisation.

---
 rtl/bpeb_term_serializer.sv | 123 ++++++++++++
 tb/tb_bpeb_term_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpeb_term_serializer.sv
// bpeb_term_serializer - radix-4 Booth digit encoder with low-digit approximation masking
// that serialises only the essential digits of each word, LSB digit first.
module bpeb_term_serializer #(
  parameter int DATA_W  = 16,
  parameter int NUM_DIG = DATA_W / 2,
  parameter int NAP_W   = 4,
  parameter int POS_W   = $clog2(NUM_DIG),
  parameter int ETC_W   = $clog2(NUM_DIG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NAP_W-1:0]  in_n_ap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_bpr,
  output logic [POS_W-1:0]  out_pos,
  output logic [ETC_W-1:0]  out_etc,
  output logic              out_last,
  output logic              out_zero
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state;
  logic [NUM_DIG-1:0]     mask_r;
  logic [3*NUM_DIG-1:0]   trip_r;

  logic [DATA_W:0]        ext;
  logic [3*NUM_DIG-1:0]   trip_in;
  logic [NUM_DIG-1:0]     ess_in;
  logic [ETC_W-1:0]       etc_in;
  logic [2:0]             raw;
  logic                   keep;

  logic                   accept;
  logic                   beat_hs;
  logic [NUM_DIG-1:0]     src_mask;
  logic [3*NUM_DIG-1:0]   src_trip;
  logic [POS_W-1:0]       nxt_pos;
  logic [2:0]             nxt_bpr;
  logic                   nxt_last;

  function automatic logic [POS_W-1:0] low_pos(input logic [NUM_DIG-1:0] m);
    low_pos = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--)
      if (m[i]) low_pos = POS_W'(i);
  endfunction

  // Appending a zero below the LSB makes every triple a plain 3-bit slice.
  always_comb begin
    ext     = {in_data, 1'b0};
    trip_in = '0;
    ess_in  = '0;
    etc_in  = '0;
    raw     = '0;
    keep    = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      raw  = ext[2*i +: 3];
      keep = (i >= int'(in_n_ap));
      trip_in[3*i +: 3] = keep ? raw : 3'b000;
      ess_in[i] = keep && (raw != 3'b000) && (raw != 3'b111);
      etc_in    = etc_in + ETC_W'(ess_in[i]);
    end
  end

  assign in_ready = !rst && ((state == IDLE) || (out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign beat_hs  = out_valid && out_ready;

  // The next beat comes either from a freshly accepted word or from the
  // current word with the digit just sent removed.
  always_comb begin
    src_mask = accept ? ess_in : (mask_r & ~(NUM_DIG'(1) << out_pos));
    src_trip = accept ? trip_in : trip_r;
    nxt_pos  = low_pos(src_mask);
    nxt_bpr  = (src_mask == '0) ? 3'b000 : src_trip[3*int'(nxt_pos) +: 3];
    nxt_last = ((src_mask & (src_mask - NUM_DIG'(1))) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mask_r    <= '0;
      trip_r    <= '0;
      out_valid <= 1'b0;
      out_bpr   <= '0;
      out_pos   <= '0;
      out_etc   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      state     <= EMIT;
      mask_r    <= ess_in;
      trip_r    <= trip_in;
      out_valid <= 1'b1;
      out_bpr   <= nxt_bpr;
      out_pos   <= nxt_pos;
      out_etc   <= etc_in;
      out_last  <= nxt_last;
      out_zero  <= (etc_in == '0);
    end else if (beat_hs) begin
      if (out_last) begin
        state     <= IDLE;
        mask_r    <= '0;
        out_valid <= 1'b0;
        out_bpr   <= '0;
        out_pos   <= '0;
        out_etc   <= '0;
        out_last  <= 1'b0;
        out_zero  <= 1'b0;
      end else begin
        mask_r   <= src_mask;
        out_bpr  <= nxt_bpr;
        out_pos  <= nxt_pos;
        out_last <= nxt_last;
      end
    end
  end

endmodule

// File: tb/tb_bpeb_term_serializer.sv
// tb/tb_bpeb_term_serializer.sv - self-checking bench for bpeb_term_serializer
// with a queue-based digit model, a directed table and random streams.
module tb_bpeb_term_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_n_ap = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_bpr;
  logic [2:0]  out_pos;
  logic [3:0]  out_etc;
  logic        out_last;
  logic        out_zero;

  bpeb_term_serializer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_n_ap(in_n_ap),
    .out_valid(out_valid), .out_ready(out_ready), .out_bpr(out_bpr), .out_pos(out_pos),
    .out_etc(out_etc), .out_last(out_last), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] bpr;
    logic [2:0] pos;
    logic [3:0] etc;
    logic       last;
    logic       zero;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  nap;
  } word_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  nap;
    logic [3:0]  etc;
    logic [3:0]  beats;
    logic [2:0]  pos0;
    logic [2:0]  bpr0;
  } vec_t;

  word_t wq[$];
  beat_t exp_q[$];
  beat_t seen[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: digit i is the arithmetic slice ((2*data) >> 2i) mod 8.
  task automatic model_push(input logic [15:0] data, input logic [3:0] nap);
    int ext, trip, cnt, done;
    int ess[8];
    beat_t b;
    ext = int'(data) * 2;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      trip   = (ext >> (2 * i)) % 8;
      ess[i] = (i >= int'(nap) && trip != 0 && trip != 7) ? trip : -1;
      if (ess[i] >= 0) cnt++;
    end
    if (cnt == 0) begin
      b = '{bpr: 3'd0, pos: 3'd0, etc: 4'd0, last: 1'b1, zero: 1'b1};
      exp_q.push_back(b);
    end else begin
      done = 0;
      for (int i = 0; i < 8; i++) begin
        if (ess[i] >= 0) begin
          done++;
          b = '{bpr: 3'(ess[i]), pos: 3'(i), etc: 4'(cnt), last: (done == cnt), zero: 1'b0};
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // ready_mode 0: always ready; 1: random ready and valid gaps; 2: stall on cycles 4..6.
  task automatic run_words(input int ready_mode, input int budget, output int cycles);
    int    cyc;
    logic  prev_stall;
    beat_t prev_out, cur;
    cyc = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    seen.delete();
    while ((wq.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wq.size() > 0 && (ready_mode != 1 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = wq[0].data;
        in_n_ap  = wq[0].nap;
      end else begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_n_ap  = 4'($urandom);
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 4 && cyc <= 6);
      endcase
      #1;
      cur = '{bpr: out_bpr, pos: out_pos, etc: out_etc, last: out_last, zero: out_zero};
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)));
      if (out_valid && exp_q.size() > 0) chk("beat", 32'(cur), 32'(exp_q[0]));
      if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        seen.push_back(cur);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        model_push(wq[0].data, wq[0].nap);
        void'(wq.pop_front());
      end
    end
    if (cyc >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles, expected under %0d", cyc, budget);
      wq.delete();
      exp_q.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles = cyc;
  endtask

  vec_t vecs[11];

  initial begin
    int cycles;
    word_t w;

    vecs[0]  = '{16'h0000, 4'd0,  4'd0, 4'd1, 3'd0, 3'b000};
    vecs[1]  = '{16'h0003, 4'd0,  4'd2, 4'd2, 3'd0, 3'b110};
    vecs[2]  = '{16'h0003, 4'd1,  4'd1, 4'd1, 3'd1, 3'b001};
    vecs[3]  = '{16'h0003, 4'd9,  4'd0, 4'd1, 3'd0, 3'b000};
    vecs[4]  = '{16'h5555, 4'd0,  4'd8, 4'd8, 3'd0, 3'b010};
    vecs[5]  = '{16'hFFFF, 4'd0,  4'd1, 4'd1, 3'd0, 3'b110};
    vecs[6]  = '{16'h8000, 4'd0,  4'd1, 4'd1, 3'd7, 3'b100};
    vecs[7]  = '{16'h5555, 4'd8,  4'd0, 4'd1, 3'd0, 3'b000};
    vecs[8]  = '{16'h5555, 4'd7,  4'd1, 4'd1, 3'd7, 3'b010};
    vecs[9]  = '{16'hAAAA, 4'd0,  4'd8, 4'd8, 3'd0, 3'b100};
    vecs[10] = '{16'hFFFF, 4'd15, 4'd0, 4'd1, 3'd0, 3'b000};

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_outs", 32'({out_valid, out_bpr, out_pos, out_etc, out_last, out_zero}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    foreach (vecs[k]) begin
      w = '{data: vecs[k].data, nap: vecs[k].nap};
      wq.push_back(w);
      run_words(0, 40, cycles);
      chk("vec_beats", 32'(seen.size()), 32'(vecs[k].beats));
      if (seen.size() > 0) begin
        chk("vec_etc", 32'(seen[0].etc), 32'(vecs[k].etc));
        chk("vec_first", 32'({seen[0].pos, seen[0].bpr}), 32'({vecs[k].pos0, vecs[k].bpr0}));
        chk("vec_last", 32'(seen[seen.size() - 1].last), 32'd1);
      end
      chk("vec_cycles", 32'(cycles), 32'(vecs[k].beats + 1));
    end

    // Three words back to back: 2 + 8 + 1 beats with only the first accept cycle spare.
    wq.push_back('{data: 16'h0003, nap: 4'd0});
    wq.push_back('{data: 16'h5555, nap: 4'd0});
    wq.push_back('{data: 16'hFFFF, nap: 4'd0});
    run_words(0, 60, cycles);
    chk("b2b_cycles", 32'(cycles), 32'd12);

    // Three stalled cycles in the middle of a word.
    wq.push_back('{data: 16'h5555, nap: 4'd0});
    run_words(2, 60, cycles);
    chk("stall_cycles", 32'(cycles), 32'd12);

    // Reset while beat pos3 of 16'h5555 is on the output.
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 16'h5555; in_n_ap = 4'd0; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_pos", 32'({out_valid, out_pos}), 32'({1'b1, 3'd3}));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_outs", 32'({out_bpr, out_pos, out_etc, out_last, out_zero}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
    wq.push_back('{data: 16'h0003, nap: 4'd0});
    run_words(0, 40, cycles);
    chk("rst_after_beats", 32'(seen.size()), 32'd2);

    // Random words with random valid gaps and backpressure.
    for (int i = 0; i < 60; i++) begin
      w.data = 16'($urandom);
      w.nap  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      wq.push_back(w);
    end
    run_words(1, 3000, cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
